// File: rtl/rate_mult_burst_ctrl.sv
// rtl/rate_mult_burst_ctrl.sv - burst sequencer for a fractional rate-multiplier core
// Holds the rate word, gates P_0 for a requested cycle count and counts Z pulses.
module rate_mult_burst_ctrl #(
    parameter int C_W   = 9,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [C_W-1:0]   cfg_c,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    output logic             core_p0,
    output logic [C_W-1:0]   core_c,
    input  logic             core_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] res_count,
    output logic             res_aborted,
    output logic             res_sat
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_LOAD = 4'b0010,
        S_RUN  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [C_W-1:0]   r_core_c;
    logic [LEN_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_res_count;
    logic             r_res_aborted;
    logic             r_res_sat;

    logic             w_run;
    logic             w_z_hit;
    logic             w_cnt_full;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sat_nxt;

    assign w_run      = (r_state == S_RUN);
    assign w_z_hit    = w_run & core_z;
    assign w_cnt_full = &r_cnt;
    assign w_cnt_nxt  = (w_z_hit && !w_cnt_full) ? r_cnt + CNT_ONE : r_cnt;
    assign w_sat_nxt  = r_sat | (w_z_hit & w_cnt_full);

    // Results are latched on entry to DONE so they are already valid while done is high.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_state       <= S_IDLE;
            r_core_c      <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_sat         <= 1'b0;
            r_res_count   <= '0;
            r_res_aborted <= 1'b0;
            r_res_sat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_core_c <= cfg_c;
                        r_rem    <= cfg_len;
                        r_cnt    <= '0;
                        r_sat    <= 1'b0;
                        if (cfg_len == '0) begin
                            r_state       <= S_DONE;
                            r_res_count   <= '0;
                            r_res_sat     <= 1'b0;
                            r_res_aborted <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state       <= S_DONE;
                        r_res_count   <= r_cnt;
                        r_res_sat     <= r_sat;
                        r_res_aborted <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_nxt;
                    r_sat <= w_sat_nxt;
                    r_rem <= r_rem - LEN_ONE;
                    // A natural end wins over a coincident abort.
                    if (r_rem == LEN_ONE || abort) begin
                        r_state       <= S_DONE;
                        r_res_count   <= w_cnt_nxt;
                        r_res_sat     <= w_sat_nxt;
                        r_res_aborted <= (r_rem != LEN_ONE);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_p0     = w_run;
    assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign cfg_ready   = (r_state == S_IDLE);
    assign core_c      = r_core_c;
    assign res_count   = r_res_count;
    assign res_aborted = r_res_aborted;
    assign res_sat     = r_res_sat;

endmodule

// File: tb/tb_rate_mult_burst_ctrl.sv
// tb/tb_rate_mult_burst_ctrl.sv - directed bench for rate_mult_burst_ctrl
module tb_rate_mult_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [8:0]  cfg_c = '0;
    logic [15:0] cfg_len = '0;
    logic        abort = 1'b0;
    logic        z_force = 1'b0;

    logic        ready, p0, busy, done, res_ab, res_sat, z;
    logic [8:0]  core_c;
    logic [15:0] res_count;
    logic        ready3, p03, busy3, done3, res_ab3, res_sat3, z3;
    logic [8:0]  core_c3;
    logic [2:0]  res_count3;
    logic [7:0]  x;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural rate-multiplier core: P_k fires on the X pattern with k-1 low ones then a zero.
    function automatic logic model_z(logic p, logic [8:0] c, logic [7:0] xv);
        logic [8:0] pk;
        logic [7:0] m;
        pk[0] = 1'b1;
        for (int k = 1; k < 9; k++) begin
            m = 8'((1 << (k - 1)) - 1);
            pk[k] = ((xv & m) == m) && !xv[k-1];
        end
        return p & |(c & pk);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) x <= '0;
        else if (p0) x <= x + 8'd1;
    end

    assign z  = z_force ? 1'b1 : model_z(p0, core_c, x);
    assign z3 = z_force ? 1'b1 : model_z(p03, core_c3, x);

    rate_mult_burst_ctrl dut (
        .blif_clk_net(clk), .blif_reset_net(rst),
        .cfg_valid(cfg_valid), .cfg_ready(ready), .cfg_c(cfg_c), .cfg_len(cfg_len),
        .abort(abort), .core_p0(p0), .core_c(core_c), .core_z(z),
        .busy(busy), .done(done), .res_count(res_count),
        .res_aborted(res_ab), .res_sat(res_sat)
    );

    rate_mult_burst_ctrl #(.CNT_W(3)) dut3 (
        .blif_clk_net(clk), .blif_reset_net(rst),
        .cfg_valid(cfg_valid), .cfg_ready(ready3), .cfg_c(cfg_c), .cfg_len(cfg_len),
        .abort(abort), .core_p0(p03), .core_c(core_c3), .core_z(z3),
        .busy(busy3), .done(done3), .res_count(res_count3),
        .res_aborted(res_ab3), .res_sat(res_sat3)
    );

    typedef struct {
        logic [8:0] c;
        int len;
        bit zf;
        int abort_at;
        bit abort_load;
        int e_cnt;
        bit e_ab;
        bit e_sat;
        int e_p0;
        int e_dk;
        int e_cnt3;
        bit e_sat3;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 300 && !done; k++) tick();
        check({name, "_done_seen"}, done, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k, runs, first, dk, ready_bad;
        string nm;
        nm = $sformatf("v%0d", idx);
        for (int w = 0; w < 20 && !ready; w++) tick();
        cfg_c = v.c;
        cfg_len = 16'(v.len);
        z_force = v.zf;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        runs = 0; first = -1; dk = -1; ready_bad = 0;
        for (k = 0; k < 300; k++) begin
            if (ready) ready_bad++;
            if (p0) begin
                runs++;
                if (first < 0) first = k;
                abort = (runs == v.abort_at);
            end else begin
                abort = v.abort_load && (k == 0);
            end
            if (done) begin
                dk = k;
                abort = 1'b0;
                break;
            end
            tick();
        end
        abort = 1'b0;
        check({nm, "_p0_cycles"}, runs, v.e_p0);
        check({nm, "_p0_first"}, first, (v.e_p0 > 0) ? 1 : -1);
        check({nm, "_done_at"}, dk, v.e_dk);
        check({nm, "_ready_busy"}, ready_bad, 0);
        tick();
        check({nm, "_done_width"}, done, 0);
        check({nm, "_idle_after"}, ready, 1);
        check({nm, "_res_count"}, res_count, v.e_cnt);
        check({nm, "_res_aborted"}, res_ab, v.e_ab);
        check({nm, "_res_sat"}, res_sat, v.e_sat);
        check({nm, "_res_count3"}, res_count3, v.e_cnt3);
        check({nm, "_res_sat3"}, res_sat3, v.e_sat3);
        check({nm, "_res_aborted3"}, res_ab3, v.e_ab);
    endtask

    initial begin
        int k;
        //            c       len  zf ab_at ld  cnt ab sat p0  dk cnt3 sat3
        vecs[0] = '{9'h001,  10, 0,   0, 0,  10, 0, 0,  10, 11, 7, 1};
        vecs[1] = '{9'h000,  20, 0,   0, 0,   0, 0, 0,  20, 21, 0, 0};
        vecs[2] = '{9'h1FF,  10, 1,   0, 0,  10, 0, 0,  10, 11, 7, 1};
        vecs[3] = '{9'h0AA,   0, 1,   0, 0,   0, 0, 0,   0,  0, 0, 0};
        vecs[4] = '{9'h155, 100, 1,   4, 0,   4, 1, 0,   4,  5, 4, 0};
        vecs[5] = '{9'h155, 100, 1, 100, 0, 100, 0, 0, 100, 101, 7, 1};
        vecs[6] = '{9'h003,   7, 1,   0, 0,   7, 0, 0,   7,  8, 7, 0};
        vecs[7] = '{9'h003,   1, 1,   1, 0,   1, 0, 0,   1,  2, 1, 0};
        vecs[8] = '{9'h0F0,   5, 1,   0, 1,   0, 1, 0,   0,  1, 0, 0};
        vecs[9] = '{9'h010,   8, 1,   0, 0,   8, 0, 0,   8,  9, 7, 1};

        repeat (3) tick();
        check("rst_p0", p0, 0);
        check("rst_core_c", core_c, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_count", res_count, 0);
        check("rst_flags", {res_ab, res_sat}, 0);
        check("rst_ready", ready, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // A second request held through a burst waits for IDLE and must not disturb core_c.
        cfg_c = 9'h0F0; cfg_len = 16'd5; z_force = 1'b1; cfg_valid = 1'b1;
        tick();
        cfg_c = 9'h00F; cfg_len = 16'd3;
        begin
            int bad;
            bad = 0;
            for (k = 0; k < 30 && !ready; k++) begin
                if (core_c !== 9'h0F0) bad++;
                tick();
            end
            check("hold_core_c_stable", bad, 0);
            check("hold_ready_at", k, 7);
            check("hold_core_c_idle", core_c, 9'h0F0);
        end
        tick();
        cfg_valid = 1'b0;
        check("hold_accept_c", core_c, 9'h00F);
        check("hold_accept_busy", busy, 1);
        wait_done("hold");
        tick();
        check("hold_res_count", res_count, 3);

        // Asynchronous reset in the middle of a run.
        cfg_c = 9'h001; cfg_len = 16'd50; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (3) tick();
        check("mid_p0_before", p0, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_p0_async", p0, 0);
        check("mid_res_count", res_count, 0);
        check("mid_ready", ready, 1);
        check("mid_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("mid_ready_after", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_mult_burst_ctrl.md
Name: rate_mult_burst_ctrl

Overview:
Sequencer for an s208-class fractional rate-multiplier core: 8-bit state counter X, enable P_0, 9-bit rate word C[8:0], output Z = OR over k of (P_k & C_k). The core's Z depends combinationally on P_0 and C. This block accepts a burst request (rate word plus cycle count) over a valid/ready handshake. It holds C stable, gates P_0 for exactly the requested number of cycles, counts Z pulses, and reports the result. It sits between the host/config logic and the core; the core shares the same clock and reset.

Parameters:
C_W, 9, rate-word width (matches core C_0..C_8)
LEN_W, 16, burst-length width in cycles
CNT_W, 16, Z-pulse counter width

Ports:
blif_clk_net  in  1  clock, rising edge
blif_reset_net  in  1  asynchronous active-high reset
cfg_valid  in  1  burst request valid
cfg_ready  out  1  controller can accept a request
cfg_c  in  C_W  rate word for the burst
cfg_len  in  LEN_W  number of P_0-enabled cycles
abort  in  1  terminate the running burst early
core_p0  out  1  drives core P_0
core_c  out  C_W  drives core C_8..C_0 (bit k -> C_k)
core_z  in  1  core Z output
busy  out  1  burst in progress (LOAD or RUN)
done  out  1  one-cycle pulse when the result is updated
res_count  out  CNT_W  Z pulses counted in the last burst
res_aborted  out  1  last burst ended by abort
res_sat  out  1  res_count saturated in the last burst

Behaviour:
- Reset is blif_reset_net, asynchronous, active-high; the clock is blif_clk_net. All flops clear on reset.
- Reset values: state=IDLE, core_p0=0, core_c=0, busy=0, done=0, res_count=0, res_aborted=0, res_sat=0. cfg_ready=1 after reset.
- States: IDLE, LOAD, RUN, DONE. Encoding is one-hot registered.
- core_p0 = (state==RUN), decoded from the state flops only. busy = LOAD|RUN. cfg_ready = (state==IDLE).
- IDLE: on cfg_valid & cfg_ready:
  - core_c <= cfg_c, rem <= cfg_len, cnt <= 0, sat <= 0.
  - Next state is LOAD, or DONE if cfg_len==0. A zero-length burst produces no P_0 cycles and reports count 0.
- LOAD: exactly one cycle with core_p0=0 and core_c at its new value. This lets the core's P/C decode settle. Next state is RUN unless abort is asserted.
- RUN, every cycle:
  - If core_z==1, cnt increments. At all-ones, cnt holds and sat is set.
  - rem decrements.
  - When rem==1, next state is DONE. core_p0 is therefore high for exactly cfg_len consecutive cycles.
- Z sampling: core_z is sampled in the same cycle core_p0 is high. There is no extra latency, because Z is combinational in P_0.
- DONE: one cycle.
  - done=1.
  - res_count <= cnt including the final RUN cycle; res_sat <= sat; res_aborted <= abort flag.
  - Next state is IDLE.
  - res_* then hold until the next DONE.
- core_c holds the last burst's word until the next accepted request. It never changes while busy.
- Abort:
  - Sampled in LOAD or RUN. Next state is DONE with the abort flag set.
  - Z in the abort cycle of RUN is counted, since P_0 was already high.
  - Abort in IDLE or DONE is ignored.
  - Abort coinciding with the final RUN cycle (rem==1) reports res_aborted=0.
- cfg_valid while not IDLE is not accepted; the requester must hold it. The request arriving during the DONE cycle is accepted in the following IDLE cycle, giving a minimum 1 idle cycle between bursts.
- The core's X counter is not reset between bursts. Z phase continues from the previous burst; that is the intended rate-multiplier behaviour.
- Reset mid-burst: core_p0 drops immediately (async), state=IDLE, and all results clear.

Test Plan:
- Reset, then cfg_c=0x001, cfg_len=10, with the real core. Expect Z=1 on every P_0 cycle, core_p0 high exactly 10 cycles starting 2 cycles after acceptance, done pulse, res_count=10, res_aborted=0.
- cfg_c=0x000, cfg_len=20 -> core_z stays 0; res_count=0, core_p0 high 20 cycles.
- Modelled core_z tied to 1, CNT_W=3, cfg_len=10 -> res_count=7, res_sat=1.
- cfg_len=0 -> no core_p0 assertion; done 1 cycle after acceptance; res_count=0.
- cfg_len=100, core_z=1, abort asserted on the 4th RUN cycle -> res_count=4, res_aborted=1, core_p0 low the next cycle. Abort on the 100th RUN cycle -> res_count=100, res_aborted=0.
- Second cfg_valid held during RUN -> cfg_ready=0 and core_c unchanged until after DONE. blif_reset_net pulsed mid-RUN -> core_p0=0 asynchronously, res_count=0, cfg_ready=1.
